// File: rtl/ctrl_reg_block.sv
// ctrl_reg_block: IPbus single-word control register block.
// Holds run-time configuration (channel enables, fill type, endianness,
// trigger settings/delay, soft-error thresholds), issues one-cycle command
// pulses and keeps saturating write/error transaction counters.
// Optional feature macro: CTRL_REG_LOCK_EN adds a lock bit at word 0x07 that
// blocks writes to 0x00-0x06 while set. Without it, 0x07 is unmapped.
// Write acks return rdata = 0; rdata carries data only for acked reads.
module ctrl_reg_block #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ipb_strobe,
  input  logic              ipb_write,
  input  logic [ADDR_W-1:0] ipb_addr,
  input  logic [31:0]       ipb_wdata,
  output logic [31:0]       ipb_rdata,
  output logic              ipb_ack,
  output logic              ipb_err,
  output logic [4:0]        chan_en,
  output logic [4:0]        fill_type,
  output logic              endianness_sel,
  output logic [2:0]        trig_settings,
  output logic [31:0]       trig_delay,
  output logic [31:0]       thres_data_corrupt,
  output logic [31:0]       thres_unknown_ttc,
  output logic [31:0]       thres_ddr3_overflow,
  output logic              clr_errors,
  output logic              clr_counters,
  output logic              force_trig
);

  localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(4'd0);
  localparam logic [ADDR_W-1:0] A_TRG  = ADDR_W'(4'd1);
  localparam logic [ADDR_W-1:0] A_DLY  = ADDR_W'(4'd2);
  localparam logic [ADDR_W-1:0] A_THC  = ADDR_W'(4'd3);
  localparam logic [ADDR_W-1:0] A_THU  = ADDR_W'(4'd4);
  localparam logic [ADDR_W-1:0] A_THD  = ADDR_W'(4'd5);
  localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(4'd6);
  localparam logic [ADDR_W-1:0] A_LOCK = ADDR_W'(4'd7);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(4'd8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic [4:0]  chan_en_r, fill_type_r;
  logic        endian_r;
  logic [2:0]  trig_set_r;
  logic [31:0] trig_delay_r, thr_dc_r, thr_ut_r, thr_do_r;
  logic [15:0] wr_cnt_r, err_cnt_r;
  logic [31:0] rdata_r, rdata_s;
  logic        ack_r, err_r, clr_err_r, clr_cnt_r, force_trig_r;
  logic        locked_s, err_s, serve_s, do_wr_s, cmd_wr_s;

`ifdef CTRL_REG_LOCK_EN
  logic lock_r;
  // Lock bit: only word 0x07 itself can change it, lock never blocks it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_r <= 1'b0;
    end else if (do_wr_s && ipb_addr == A_LOCK) begin
      lock_r <= ipb_wdata[0];
    end else begin
      lock_r <= lock_r;
    end
  end
  assign locked_s = lock_r;
`else
  assign locked_s = 1'b0;
`endif

  // A transaction is served exactly once: only in IDLE with strobe high.
  assign serve_s  = (state_r == ST_IDLE) && ipb_strobe;
  assign do_wr_s  = serve_s && ipb_write && !err_s;
  assign cmd_wr_s = do_wr_s && (ipb_addr == A_CMD);

  // Address decode: read mux and error classification for the current request.
  always_comb begin
    rdata_s = 32'h0000_0000;
    err_s   = 1'b0;
    case (ipb_addr)
      A_CFG:  rdata_s = {21'd0, endian_r, fill_type_r, chan_en_r};
      A_TRG:  rdata_s = {29'd0, trig_set_r};
      A_DLY:  rdata_s = trig_delay_r;
      A_THC:  rdata_s = thr_dc_r;
      A_THU:  rdata_s = thr_ut_r;
      A_THD:  rdata_s = thr_do_r;
      A_CMD:  rdata_s = 32'h0000_0000;
`ifdef CTRL_REG_LOCK_EN
      A_LOCK: rdata_s = {31'd0, lock_r};
`endif
      A_STAT: begin
        rdata_s = {err_cnt_r, wr_cnt_r};
        err_s   = ipb_write;
      end
      default: err_s = 1'b1;
    endcase
    if (ipb_write && locked_s && (ipb_addr <= A_CMD)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: respond once, then wait for the master to drop strobe.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (ipb_strobe) state_nx_s = ST_RESP; else state_nx_s = ST_IDLE;
      ST_RESP: if (ipb_strobe) state_nx_s = ST_WAIT; else state_nx_s = ST_IDLE;
      ST_WAIT: if (!ipb_strobe) state_nx_s = ST_IDLE; else state_nx_s = ST_WAIT;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Response, read data and command pulses; all last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r        <= 1'b0;
      err_r        <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      clr_err_r    <= 1'b0;
      clr_cnt_r    <= 1'b0;
      force_trig_r <= 1'b0;
    end else begin
      ack_r        <= serve_s && !err_s;
      err_r        <= serve_s && err_s;
      rdata_r      <= (serve_s && !err_s && !ipb_write) ? rdata_s : 32'h0000_0000;
      clr_err_r    <= cmd_wr_s && ipb_wdata[0];
      clr_cnt_r    <= cmd_wr_s && ipb_wdata[1];
      force_trig_r <= cmd_wr_s && ipb_wdata[2];
    end
  end

  // Configuration registers; reserved write bits are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      chan_en_r    <= 5'h1F;
      fill_type_r  <= 5'h00;
      endian_r     <= 1'b0;
      trig_set_r   <= 3'd0;
      trig_delay_r <= 32'h0000_0000;
      thr_dc_r     <= 32'hFFFF_FFFF;
      thr_ut_r     <= 32'hFFFF_FFFF;
      thr_do_r     <= 32'hFFFF_FFFF;
    end else if (do_wr_s) begin
      case (ipb_addr)
        A_CFG: begin
          chan_en_r   <= ipb_wdata[4:0];
          fill_type_r <= ipb_wdata[9:5];
          endian_r    <= ipb_wdata[10];
        end
        A_TRG:   trig_set_r   <= ipb_wdata[2:0];
        A_DLY:   trig_delay_r <= ipb_wdata;
        A_THC:   thr_dc_r     <= ipb_wdata;
        A_THU:   thr_ut_r     <= ipb_wdata;
        A_THD:   thr_do_r     <= ipb_wdata;
        default: trig_set_r   <= trig_set_r;
      endcase
    end else begin
      trig_set_r <= trig_set_r;
    end
  end

  // Saturating transaction counters; a clr_counters command wins over the
  // increment caused by that same command write.
  always_ff @(posedge clk) begin
    if (reset || (cmd_wr_s && ipb_wdata[1])) begin
      wr_cnt_r  <= 16'h0000;
      err_cnt_r <= 16'h0000;
    end else begin
      if (do_wr_s && wr_cnt_r != 16'hFFFF) wr_cnt_r <= wr_cnt_r + 16'h0001;
      else wr_cnt_r <= wr_cnt_r;
      if (serve_s && err_s && err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'h0001;
      else err_cnt_r <= err_cnt_r;
    end
  end

  assign ipb_rdata           = rdata_r;
  assign ipb_ack             = ack_r;
  assign ipb_err             = err_r;
  assign chan_en             = chan_en_r;
  assign fill_type           = fill_type_r;
  assign endianness_sel      = endian_r;
  assign trig_settings       = trig_set_r;
  assign trig_delay          = trig_delay_r;
  assign thres_data_corrupt  = thr_dc_r;
  assign thres_unknown_ttc   = thr_ut_r;
  assign thres_ddr3_overflow = thr_do_r;
  assign clr_errors          = clr_err_r;
  assign clr_counters        = clr_cnt_r;
  assign force_trig          = force_trig_r;

endmodule
